interval_meter_mc: RTL and testbench



---
 rtl/interval_meter_mc.sv | 245 ++++++++++++++++++++++++
 tb/tb_interval_meter_mc.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_meter_mc.sv
// interval_meter_mc: multi-channel start/stop time-interval meter.
// Each channel counts prescaled ticks between a start edge and a stop edge,
// single-shot or continuous, and is read through a byte-wide register bus.
// Optional feature macro: INTERVAL_IRQ_EN (adds per-channel irq mask and irq port).
module interval_meter_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRESC  = 10,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] start_in,
  input  logic [NUM_CH-1:0] stop_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic              wr,
  input  logic              rd,
  output logic [7:0]        rdata
`ifdef INTERVAL_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

  // ---------------------------------------------------------------- prescaler
  logic [PW-1:0] presc_reg;
  logic          tick;

  assign tick = (presc_reg == PW'(PRESC - 1));

  // Free-running prescaler shared by all channels; tick marks the wrap.
  always_ff @(posedge clk) begin
    if (rst)       presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + PW'(1);
  end

  // ------------------------------------------------------------ synchronisers
  logic [NUM_CH-1:0] start_s1_reg, start_s2_reg, start_s3_reg;
  logic [NUM_CH-1:0] stop_s1_reg, stop_s2_reg, stop_s3_reg;

  // Two-flop synchronisers plus one history stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_s1_reg <= '0;
      start_s2_reg <= '0;
      start_s3_reg <= '0;
      stop_s1_reg  <= '0;
      stop_s2_reg  <= '0;
      stop_s3_reg  <= '0;
    end else begin
      start_s1_reg <= start_in;
      start_s2_reg <= start_s1_reg;
      start_s3_reg <= start_s2_reg;
      stop_s1_reg  <= stop_in;
      stop_s2_reg  <= stop_s1_reg;
      stop_s3_reg  <= stop_s2_reg;
    end
  end

  // ---------------------------------------------------------- address decode
  logic [IDX_W-1:0] ch_sel;
  logic [SEL_W-1:0] ch_idx;
  logic [2:0]       reg_sel;
  logic             ch_valid;
  logic             unused_wdata;

  assign ch_sel       = addr[ADDR_W-1:3];
  assign ch_idx       = ch_sel[SEL_W-1:0];
  assign reg_sel      = addr[2:0];
  assign ch_valid     = (32'(ch_sel) < NUM_CH);
  assign unused_wdata = ^wdata[7:5];

  // Per-channel values gathered for the read multiplexer.
  logic [CNT_W-1:0]  result_all [NUM_CH];
  logic [CNT_W-1:0]  shadow_all [NUM_CH];
  logic [7:0]        status_all [NUM_CH];
  logic [7:0]        ctrl_all   [NUM_CH];
  logic [NUM_CH-1:0] mask_all;
  logic [NUM_CH-1:0] irq_src;

  // ---------------------------------------------------------------- channels
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             hit, ctrl_wr, arm_wr, abort_wr, stat_rd, byte0_rd;
    logic             start_evt_reg, stop_evt_reg;
    logic             capture, sat;
    logic [CNT_W-1:0] count_reg, result_reg, shadow_reg;
    logic             done_reg, ovf_reg, cont_reg, spol_reg, tpol_reg, mask_reg;
    state_t           state_reg, state_next;

    assign hit      = ch_valid && (32'(ch_sel) == gi);
    assign ctrl_wr  = wr && hit && (reg_sel == 3'd5);
    assign abort_wr = ctrl_wr && wdata[4];
    assign arm_wr   = ctrl_wr && wdata[0] && !wdata[4];
    assign stat_rd  = rd && hit && (reg_sel == 3'd4);
    assign byte0_rd = rd && hit && (reg_sel == 3'd0);
    assign sat      = (count_reg == CNT_MAX);

    // Registered event pulses on the selected edge of each synchronised pin.
    always_ff @(posedge clk) begin
      if (rst) begin
        start_evt_reg <= 1'b0;
        stop_evt_reg  <= 1'b0;
      end else begin
        start_evt_reg <= spol_reg ? (~start_s2_reg[gi] & start_s3_reg[gi])
                                  : (start_s2_reg[gi] & ~start_s3_reg[gi]);
        stop_evt_reg  <= tpol_reg ? (~stop_s2_reg[gi] & stop_s3_reg[gi])
                                  : (stop_s2_reg[gi] & ~stop_s3_reg[gi]);
      end
    end

    // Measurement FSM next-state logic; abort overrides every state.
    always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      if (abort_wr) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE:    if (arm_wr) state_next = ARMED;
          ARMED:   if (start_evt_reg) state_next = COUNT;
          COUNT: begin
            if (stop_evt_reg || sat) begin
              state_next = DONE;
              capture    = 1'b1;
            end
          end
          DONE:    state_next = cont_reg ? ARMED : IDLE;
          default: state_next = IDLE;
        endcase
      end
    end

    // Channel state, counter, result capture, status flags and snapshot.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg  <= IDLE;
        count_reg  <= '0;
        result_reg <= '0;
        shadow_reg <= '0;
        done_reg   <= 1'b0;
        ovf_reg    <= 1'b0;
        cont_reg   <= 1'b0;
        spol_reg   <= 1'b0;
        tpol_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        if (abort_wr || (state_reg == ARMED && start_evt_reg))
          count_reg <= '0;
        else if (state_reg == COUNT && tick && !sat)
          count_reg <= count_reg + CNT_W'(1);
        // Configuration is only taken when a new measurement is armed.
        if (state_reg == IDLE && arm_wr) begin
          cont_reg <= wdata[1];
          spol_reg <= wdata[2];
          tpol_reg <= wdata[3];
        end
        // A completion in the same clk as a STATUS read keeps the new flags.
        if (capture) begin
          result_reg <= count_reg;
          done_reg   <= 1'b1;
          ovf_reg    <= sat;
        end else if (stat_rd) begin
          done_reg <= 1'b0;
          ovf_reg  <= 1'b0;
        end
        if (byte0_rd) shadow_reg <= result_reg;
      end
    end

`ifdef INTERVAL_IRQ_EN
    // Interrupt mask bit for this channel.
    always_ff @(posedge clk) begin
      if (rst)                                     mask_reg <= 1'b0;
      else if (wr && hit && (reg_sel == 3'd6))     mask_reg <= wdata[0];
    end
`else
    assign mask_reg = 1'b0;
`endif

    assign result_all[gi] = result_reg;
    assign shadow_all[gi] = shadow_reg;
    assign status_all[gi] = {4'b0, cont_reg, (state_reg == ARMED) || (state_reg == COUNT),
                             ovf_reg, done_reg};
    assign ctrl_all[gi]   = {4'b0, tpol_reg, spol_reg, cont_reg, 1'b0};
    assign mask_all[gi]   = mask_reg;
    assign irq_src[gi]    = done_reg & mask_reg;
  end

  // ----------------------------------------------------------------- readout
  logic [7:0]  rd_mux;
  logic [31:0] res32, shd32;
  logic [7:0]  rdata_reg;

  // Register read multiplexer; unmapped channels and offsets read zero.
  always_comb begin
    rd_mux = 8'h00;
    res32  = 32'(result_all[ch_idx]);
    shd32  = 32'(shadow_all[ch_idx]);
    if (ch_valid) begin
      case (reg_sel)
        3'd0:    rd_mux = res32[7:0];
        3'd1:    rd_mux = shd32[15:8];
        3'd2:    rd_mux = shd32[23:16];
        3'd3:    rd_mux = shd32[31:24];
        3'd4:    rd_mux = status_all[ch_idx];
        3'd5:    rd_mux = ctrl_all[ch_idx];
        3'd6:    rd_mux = {7'b0, mask_all[ch_idx]};
        default: rd_mux = 8'h00;
      endcase
    end
  end

  // Read data is captured on the rd strobe and held until the next one.
  always_ff @(posedge clk) begin
    if (rst)     rdata_reg <= 8'h00;
    else if (rd) rdata_reg <= rd_mux;
  end

  assign rdata = rdata_reg;

`ifdef INTERVAL_IRQ_EN
  logic irq_reg;

  // Registered OR of all masked done flags.
  always_ff @(posedge clk) begin
    if (rst) irq_reg <= 1'b0;
    else     irq_reg <= |irq_src;
  end

  assign irq = irq_reg;
`else
  logic unused_irq;
  assign unused_irq = ^irq_src;
`endif

endmodule

// File: tb/tb_interval_meter_mc.sv
// Self-checking bench for interval_meter_mc: reset, single-shot, randomized
// measurements, continuous mode, overflow, snapshot coherence, address bounds
// and (with INTERVAL_IRQ_EN) the interrupt path.
module tb_interval_meter_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRESC  = 10;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic              rst;
  logic [NUM_CH-1:0] start_pin, stop_pin;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata, rdata;
  logic              wr, rd;
  logic [1:0]        start1, stop1;
  logic [7:0]        addr1, wdata1, rdata1;
  logic              wr1, rd1;
`ifdef INTERVAL_IRQ_EN
  logic irq, irq1;
`endif

  int checks = 0;
  int errors = 0;

  interval_meter_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC(PRESC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start_in(start_pin), .stop_in(stop_pin),
    .addr(addr), .wdata(wdata), .wr(wr), .rd(rd), .rdata(rdata)
`ifdef INTERVAL_IRQ_EN
    , .irq(irq)
`endif
  );

  // Small instance for the saturation case: 9-bit counter, tick every clk.
  interval_meter_mc #(.NUM_CH(2), .CNT_W(9), .PRESC(1), .ADDR_W(8)) dut_ovf (
    .clk(clk), .rst(rst), .start_in(start1), .stop_in(stop1),
    .addr(addr1), .wdata(wdata1), .wr(wr1), .rd(rd1), .rdata(rdata1)
`ifdef INTERVAL_IRQ_EN
    , .irq(irq1)
`endif
  );

  // Reference: an interval of d clk equals d/PRESC ticks (tolerance 1).
  function automatic int model_ticks(input int d);
    return d / PRESC;
  endfunction

  task automatic bus_write(input int d, input int ch, input int r, input logic [7:0] v);
    @(negedge clk);
    if (d == 0) begin addr = 8'(ch * 8 + r); wdata = v; wr = 1'b1; end
    else        begin addr1 = 8'(ch * 8 + r); wdata1 = v; wr1 = 1'b1; end
    @(negedge clk);
    wr = 1'b0; wr1 = 1'b0;
    $display("  wr dut%0d ch%0d reg%0d <= %02h", d, ch, r, v);
  endtask

  task automatic bus_read(input int d, input int ch, input int r, output logic [7:0] v);
    @(negedge clk);
    if (d == 0) begin addr = 8'(ch * 8 + r); rd = 1'b1; end
    else        begin addr1 = 8'(ch * 8 + r); rd1 = 1'b1; end
    @(negedge clk);
    rd = 1'b0; rd1 = 1'b0;
    v = (d == 0) ? rdata : rdata1;
    $display("  rd dut%0d ch%0d reg%0d -> %02h", d, ch, r, v);
  endtask

  task automatic read_result(input int d, input int ch, output int unsigned val);
    logic [7:0] b;
    val = 0;
    for (int k = 0; k < 4; k++) begin
      bus_read(d, ch, k, b);
      val = val | (32'(b) << (8 * k));
    end
  endtask

  task automatic set_idle(input int ch, input bit falling);
    @(negedge clk);
    start_pin[ch] = falling;
    stop_pin[ch]  = falling;
    repeat (6) @(negedge clk);
  endtask

  // Active start edge, then active stop edge 'delay' clk later, then back to idle.
  task automatic pulse_pair(input int ch, input int delay, input bit falling);
    @(negedge clk);
    start_pin[ch] = ~falling;
    repeat (delay) @(negedge clk);
    stop_pin[ch] = ~falling;
    repeat (12) @(negedge clk);
    start_pin[ch] = falling;
    stop_pin[ch]  = falling;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] b;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", rdata); end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bus_read(0, ch, 4, b);
      checks++;
      if (b !== 8'h00) begin errors++; $display("FAIL reset_status ch%0d: got %02h expected 00", ch, b); end
      bus_read(0, ch, 0, b);
      checks++;
      if (b !== 8'h00) begin errors++; $display("FAIL reset_result0 ch%0d: got %02h expected 00", ch, b); end
      bus_read(0, ch, 3, b);
      checks++;
      if (b !== 8'h00) begin errors++; $display("FAIL reset_result3 ch%0d: got %02h expected 00", ch, b); end
    end
  endtask

  task automatic test_single_shot;
    logic [7:0] b;
    int unsigned val;
    int exp;
    set_idle(0, 1'b0);
    bus_write(0, 0, 5, 8'h01);
    bus_read(0, 0, 4, b);
    checks++;
    if (b !== 8'h04) begin errors++; $display("FAIL single_armed_status: got %02h expected 04", b); end
    pulse_pair(0, 1000, 1'b0);
    read_result(0, 0, val);
    exp = model_ticks(1000);
    checks++;
    if (int'(val) < exp - 1 || int'(val) > exp + 1) begin
      errors++; $display("FAIL single_result: got %0d expected %0d+-1", val, exp);
    end
    bus_read(0, 0, 4, b);
    checks++;
    if (b !== 8'h01) begin errors++; $display("FAIL single_status: got %02h expected 01", b); end
    bus_read(0, 0, 4, b);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL single_status_reread: got %02h expected 00", b); end
  endtask

  task automatic test_random;
    logic [7:0] b, ctl;
    int unsigned val;
    int ch, delay, exp;
    bit falling;
    for (int it = 0; it < 6; it++) begin
      ch      = int'($urandom_range(0, NUM_CH - 1));
      delay   = int'($urandom_range(30, 2000));
      falling = 1'($urandom_range(0, 1));
      ctl     = falling ? 8'h0D : 8'h01;
      set_idle(ch, falling);
      bus_write(0, ch, 5, ctl);
      bus_read(0, ch, 5, b);
      checks++;
      if (b !== (ctl & 8'h0E)) begin
        errors++; $display("FAIL random_ctrl_readback ch%0d: got %02h expected %02h", ch, b, ctl & 8'h0E);
      end
      pulse_pair(ch, delay, falling);
      read_result(0, ch, val);
      exp = model_ticks(delay);
      checks++;
      if (int'(val) < exp - 1 || int'(val) > exp + 1) begin
        errors++; $display("FAIL random_result ch%0d delay %0d: got %0d expected %0d+-1", ch, delay, val, exp);
      end
      bus_read(0, ch, 4, b);
      checks++;
      if (b !== 8'h01) begin errors++; $display("FAIL random_status ch%0d: got %02h expected 01", ch, b); end
    end
  endtask

  task automatic test_continuous;
    logic [7:0] b;
    int unsigned val;
    int exp;
    exp = model_ticks(500);
    set_idle(2, 1'b0);
    bus_write(0, 2, 5, 8'h03);
    for (int n = 0; n < 3; n++) begin
      pulse_pair(2, 500, 1'b0);
      read_result(0, 2, val);
      checks++;
      if (int'(val) < exp - 1 || int'(val) > exp + 1) begin
        errors++; $display("FAIL cont_result run%0d: got %0d expected %0d+-1", n, val, exp);
      end
      bus_read(0, 2, 4, b);
      checks++;
      if (b !== 8'h0D) begin errors++; $display("FAIL cont_status run%0d: got %02h expected 0d", n, b); end
    end
    bus_write(0, 2, 5, 8'h10);
    bus_read(0, 2, 4, b);
    checks++;
    if (b !== 8'h08) begin errors++; $display("FAIL cont_abort_status: got %02h expected 08", b); end
    bus_read(0, 2, 0, b);
    checks++;
    if (int'(b) < exp - 1 || int'(b) > exp + 1) begin
      errors++; $display("FAIL cont_abort_result: got %0d expected %0d+-1", b, exp);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    int unsigned val;
    bus_write(1, 0, 5, 8'h01);
    @(negedge clk);
    start1[0] = 1'b1;
    repeat (600) @(negedge clk);
    read_result(1, 0, val);
    checks++;
    if (val !== 32'h1FF) begin errors++; $display("FAIL ovf_result: got %0h expected 1ff", val); end
    bus_read(1, 0, 4, b);
    checks++;
    if (b !== 8'h03) begin errors++; $display("FAIL ovf_status: got %02h expected 03", b); end
    start1[0] = 1'b0;
  endtask

  task automatic test_snapshot;
    logic [7:0] b;
    int unsigned val;
    int exp_a, exp_b;
    exp_a = model_ticks(3000);
    exp_b = model_ticks(6000);
    set_idle(1, 1'b0);
    bus_write(0, 1, 5, 8'h01);
    pulse_pair(1, 3000, 1'b0);
    read_result(0, 1, val);
    checks++;
    if (int'(val) < exp_a - 1 || int'(val) > exp_a + 1) begin
      errors++; $display("FAIL snap_first_result: got %0d expected %0d+-1", val, exp_a);
    end
    bus_read(0, 1, 4, b);
    // Second measurement: byte0 is read while it is still running.
    bus_write(0, 1, 5, 8'h01);
    @(negedge clk);
    start_pin[1] = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(0, 1, 0, b);
    checks++;
    if (int'(b) < (exp_a - 1) % 256 || int'(b) > (exp_a + 1) % 256) begin
      errors++; $display("FAIL snap_byte0: got %02h expected %02h+-1", b, exp_a % 256);
    end
    repeat (6000 - 102) @(negedge clk);
    stop_pin[1] = 1'b1;
    repeat (12) @(negedge clk);
    start_pin[1] = 1'b0;
    stop_pin[1]  = 1'b0;
    for (int k = 1; k < 4; k++) begin
      bus_read(0, 1, k, b);
      checks++;
      if (int'(b) !== ((exp_a >> (8 * k)) & 255)) begin
        errors++; $display("FAIL snap_old_byte%0d: got %02h expected %02h", k, b, (exp_a >> (8 * k)) & 255);
      end
    end
    read_result(0, 1, val);
    checks++;
    if (int'(val) < exp_b - 1 || int'(val) > exp_b + 1) begin
      errors++; $display("FAIL snap_new_result: got %0d expected %0d+-1", val, exp_b);
    end
    bus_read(0, 1, 4, b);
    // Falling-edge measurement on the same channel.
    set_idle(1, 1'b1);
    bus_write(0, 1, 5, 8'h0D);
    pulse_pair(1, 700, 1'b1);
    read_result(0, 1, val);
    checks++;
    if (int'(val) < model_ticks(700) - 1 || int'(val) > model_ticks(700) + 1) begin
      errors++; $display("FAIL falling_result: got %0d expected %0d+-1", val, model_ticks(700));
    end
    bus_read(0, 1, 4, b);
    checks++;
    if (b !== 8'h01) begin errors++; $display("FAIL falling_status: got %02h expected 01", b); end
  endtask

  task automatic test_addr_bounds;
    logic [7:0] b;
    bus_write(0, 5, 5, 8'h0E);
    bus_read(0, 5, 5, b);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL bad_ch_ctrl: got %02h expected 00", b); end
    bus_read(0, 0, 7, b);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL reserved_reg: got %02h expected 00", b); end
`ifndef INTERVAL_IRQ_EN
    bus_write(0, 0, 6, 8'h01);
    bus_read(0, 0, 6, b);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL mask_absent: got %02h expected 00", b); end
`endif
    bus_write(0, 3, 5, 8'h1F);
    bus_read(0, 3, 4, b);
    checks++;
    if ((b & 8'h04) !== 8'h00) begin errors++; $display("FAIL abort_over_arm busy: got %02h expected bit2 0", b); end
    bus_write(0, 3, 5, 8'h03);
    bus_read(0, 3, 5, b);
    checks++;
    if (b !== 8'h02) begin errors++; $display("FAIL ctrl_readback: got %02h expected 02", b); end
    bus_read(0, 3, 4, b);
    checks++;
    if (b !== 8'h0C) begin errors++; $display("FAIL armed_cont_status: got %02h expected 0c", b); end
    bus_write(0, 3, 5, 8'h10);
    bus_read(0, 3, 4, b);
    checks++;
    if (b !== 8'h08) begin errors++; $display("FAIL abort_status: got %02h expected 08", b); end
  endtask

`ifdef INTERVAL_IRQ_EN
  task automatic test_irq;
    logic [7:0] b;
    bus_write(0, 3, 6, 8'h01);
    bus_read(0, 3, 6, b);
    checks++;
    if (b !== 8'h01) begin errors++; $display("FAIL irq_mask_readback: got %02h expected 01", b); end
    set_idle(3, 1'b0);
    bus_write(0, 3, 5, 8'h01);
    pulse_pair(3, 200, 1'b0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    bus_read(0, 3, 4, b);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    set_idle(0, 1'b0);
    bus_write(0, 0, 5, 8'h01);
    pulse_pair(0, 200, 1'b0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked: got %b expected 0", irq); end
    bus_read(0, 0, 4, b);
  endtask
`endif

  task automatic test_reset_again;
    logic [7:0] b;
    bus_read(0, 1, 0, b);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL rereset_rdata: got %02h expected 00", rdata); end
    bus_read(0, 1, 0, b);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL rereset_result: got %02h expected 00", b); end
    bus_read(0, 1, 5, b);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL rereset_ctrl: got %02h expected 00", b); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_pin = '0; stop_pin = '0;
    addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
    start1 = '0; stop1 = '0;
    addr1 = '0; wdata1 = '0; wr1 = 1'b0; rd1 = 1'b0;
    test_reset;
    test_single_shot;
    test_random;
    test_continuous;
    test_overflow;
    test_snapshot;
    test_addr_bounds;
`ifdef INTERVAL_IRQ_EN
    test_irq;
`endif
    test_reset_again;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
